parallel_serial_if_ml: RTL and testbench
========================================

PARALLEL_SERIAL_IF_ML -- requirements
Module: parallel_serial_if_ml

Interface
REQ-001 Parameter DATA_WIDTH, default 171, SHALL be the frame payload width in bits (>=1).
REQ-002 Parameter LANES, default 1, SHALL be the number of parallel serial data lanes (1..DATA_WIDTH).
REQ-003 Parameter CLK_DIV, default 1, SHALL be the ser_clk half-period in clk cycles (>=1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-006 i_valid  input  1  SHALL be the frame-request strobe.
REQ-007 o_ready  output  1  SHALL be high only in IDLE; a frame is accepted on a rising edge with i_valid&o_ready.
REQ-008 i_data  input  DATA_WIDTH  SHALL be the transmit payload, sampled only on the accepting edge.
REQ-009 o_valid  output  1  SHALL be a one-cycle pulse marking o_data updated.
REQ-010 o_data  output  DATA_WIDTH  SHALL be the registered receive payload of the last completed frame.
REQ-011 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-012 ser_clk  output  1  SHALL be the generated serial clock, idle low.
REQ-013 ser_cs  output  1  SHALL be the active-low frame select.
REQ-014 ser_data_out  output  LANES  SHALL carry the current transmit beat; bit LANES-1 is the most significant lane.
REQ-015 ser_data_in  input  LANES  SHALL carry receive data, same lane ordering.

Function
REQ-016 BEATS SHALL equal ceil(DATA_WIDTH/LANES); the shift registers SHALL be BEATS*LANES bits, payload left-aligned, pad bits zero at the LSB end.
REQ-017 States SHALL be IDLE, SETUP, SHIFT, HOLD; an accept moves IDLE->SETUP.
REQ-018 SETUP SHALL last CLK_DIV cycles with ser_cs=0, ser_clk=0 and ser_data_out = beat 0 (top LANES bits of tx register).
REQ-019 SHIFT SHALL last 2*BEATS*CLK_DIV cycles: per beat, ser_clk high CLK_DIV cycles then low CLK_DIV cycles.
REQ-020 ser_data_in SHALL be sampled on the clk edge where ser_clk goes 0->1 and shifted into the rx register LSB end, LANES bits per beat.
REQ-021 The tx register SHALL shift left by LANES on each ser_clk 1->0 transition except after the last beat; ser_data_out changes only there.
REQ-022 After the last low phase the FSM SHALL enter HOLD: ser_cs=1, ser_clk=0, ser_data_out=0 for CLK_DIV cycles, then IDLE.
REQ-023 On HOLD entry o_data SHALL load the top DATA_WIDTH bits of the rx register (pad bits discarded) and o_valid SHALL pulse for exactly that first HOLD cycle.
REQ-024 o_valid SHALL be high in cycle CLK_DIV*(2*BEATS+1)+1 counted from the accepting edge (cycle 0).
REQ-025 i_valid outside IDLE SHALL be ignored and not queued; i_data changes during a frame SHALL not affect ser_data_out.
REQ-026 Minimum ser_cs-high gap between back-to-back frames SHALL be CLK_DIV+1 cycles (HOLD plus one IDLE cycle).
REQ-027 o_data SHALL hold its value between frames.
REQ-028 Divider and beat counters SHALL be sized for CLK_DIV and BEATS and SHALL not wrap within a frame.

Reset
REQ-029 While rst_n=0 at a clk edge, next state SHALL be IDLE with o_ready=1, o_busy=0, o_valid=0, o_data=0, ser_cs=1, ser_clk=0, ser_data_out=0, counters and shift registers 0.
REQ-030 Reset asserted mid-frame SHALL abort it with no o_valid pulse and o_data unchanged from reset value 0.

Verification
REQ-031 DATA_WIDTH=8, LANES=1, CLK_DIV=1, ser_data_in looped from ser_data_out, i_data=0xA5 -> lane sequence 1,0,1,0,0,1,0,1, 8 ser_clk rising edges, o_valid in cycle 18, o_data=0xA5.
REQ-032 DATA_WIDTH=10, LANES=4, CLK_DIV=1, loopback, i_data=0x2D3 -> beats 0xB,0x4,0xC, 3 ser_clk pulses, o_valid in cycle 8, o_data=0x2D3.
REQ-033 DATA_WIDTH=8, LANES=1, CLK_DIV=3 -> ser_clk high 3/low 3 cycles, SETUP 3 cycles, o_valid in cycle 52, HOLD 3 cycles.
REQ-034 i_valid held high over two frames (8/1/1) -> second accept in first IDLE cycle after HOLD, ser_cs high exactly 2 cycles between frames, i_valid during busy causes no extra frame.
REQ-035 rst_n=0 for one cycle during SHIFT beat 3 -> next cycle all outputs at reset values, no o_valid, next i_valid starts a full fresh frame.

Source files
------------

// File: rtl/parallel_serial_if_ml.sv
// parallel_serial_if_ml
//   Frames a DATA_WIDTH-bit parallel word onto LANES serial lanes with a
//   generated serial clock and active-low select. Receive data is captured in
//   the same frame and presented as a registered parallel word.
//
//   Ports:
//     clk, rst_n          single clock, synchronous active-low reset
//     i_valid / o_ready   frame request handshake (o_ready only in IDLE)
//     i_data              payload, sampled on the accepting edge
//     o_valid / o_data    one-cycle pulse + registered payload of last frame
//     o_busy              high outside IDLE
//     ser_clk, ser_cs     serial clock (idle low), frame select (active low)
//     ser_data_out/in     per-beat lane data, bit LANES-1 is the MSB lane
module parallel_serial_if_ml #(
  parameter int DATA_WIDTH = 171,
  parameter int LANES      = 1,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  ser_clk,
  output logic                  ser_cs,
  output logic [LANES-1:0]      ser_data_out,
  input  logic [LANES-1:0]      ser_data_in
);

  localparam int BEATS  = (DATA_WIDTH + LANES - 1) / LANES;
  localparam int SR_W   = BEATS * LANES;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div_cnt, div_nxt;
  logic [BEAT_W-1:0]       beat_cnt, beat_nxt;
  logic                    sclk_q, sclk_nxt;
  logic [SR_W-1:0]         tx_sr, tx_nxt;
  logic [SR_W-1:0]         rx_sr, rx_nxt;
  logic                    vld_q, vld_nxt;
  logic [DATA_WIDTH-1:0]   data_q, data_nxt;
  logic [SR_W-1:0]         tx_load;
  logic [SR_W-1:0]         rx_shift;

  // Receive shifts in at the LSB end; older beats move toward the MSB.
  assign rx_shift = (rx_sr << LANES) | SR_W'(ser_data_in);

  always_comb begin
    // Payload left-aligned; pad bits at the LSB end stay zero.
    tx_load = '0;
    tx_load[SR_W-1 -: DATA_WIDTH] = i_data;

    state_nxt = state;
    div_nxt   = div_cnt;
    beat_nxt  = beat_cnt;
    sclk_nxt  = sclk_q;
    tx_nxt    = tx_sr;
    rx_nxt    = rx_sr;
    vld_nxt   = 1'b0;
    data_nxt  = data_q;

    case (state)
      IDLE: begin
        if (i_valid) begin
          state_nxt = SETUP;
          tx_nxt    = tx_load;
          rx_nxt    = '0;
          div_nxt   = '0;
          beat_nxt  = '0;
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          rx_nxt    = rx_shift;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (sclk_q) begin
            // Falling edge: advance to the next beat unless this was the last.
            sclk_nxt = 1'b0;
            if (beat_cnt != BEAT_LAST) tx_nxt = tx_sr << LANES;
          end else if (beat_cnt == BEAT_LAST) begin
            state_nxt = HOLD;
            vld_nxt   = 1'b1;
            data_nxt  = rx_sr[SR_W-1 -: DATA_WIDTH];
          end else begin
            // Rising edge: capture the receive beat.
            beat_nxt = beat_cnt + BEAT_W'(1);
            sclk_nxt = 1'b1;
            rx_nxt   = rx_shift;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      beat_cnt <= '0;
      sclk_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      beat_cnt <= beat_nxt;
      sclk_q   <= sclk_nxt;
      tx_sr    <= tx_nxt;
      rx_sr    <= rx_nxt;
      vld_q    <= vld_nxt;
      data_q   <= data_nxt;
    end
  end

  assign o_ready      = (state == IDLE);
  assign o_busy       = (state != IDLE);
  assign o_valid      = vld_q;
  assign o_data       = data_q;
  assign ser_clk      = sclk_q;
  assign ser_cs       = !((state == SETUP) || (state == SHIFT));
  assign ser_data_out = ((state == SETUP) || (state == SHIFT)) ? tx_sr[SR_W-1 -: LANES] : '0;

endmodule

// File: tb/tb_parallel_serial_if_ml.sv
module tb_parallel_serial_if_ml;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0]       iv = '0;
  logic [NU-1:0][9:0]  id = '0;
  wire  [NU-1:0]       ordy, ov, busy, sclk, scs;
  wire  [NU-1:0][9:0]  od;
  wire  [NU-1:0][3:0]  sdo;

  // unit 0: 8/1/1, unit 1: 10/4/1, unit 2: 8/1/3, all in loopback
  int cw [NU] = '{8, 10, 8};
  int cl [NU] = '{1, 4, 1};
  int cd [NU] = '{1, 1, 3};

  assign od[0][9:8]  = 2'b0;
  assign sdo[0][3:1] = 3'b0;
  assign od[2][9:8]  = 2'b0;
  assign sdo[2][3:1] = 3'b0;

  parallel_serial_if_ml #(.DATA_WIDTH(8), .LANES(1), .CLK_DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[0]), .o_ready(ordy[0]), .i_data(id[0][7:0]),
    .o_valid(ov[0]), .o_data(od[0][7:0]), .o_busy(busy[0]), .ser_clk(sclk[0]),
    .ser_cs(scs[0]), .ser_data_out(sdo[0][0:0]), .ser_data_in(sdo[0][0:0]));

  parallel_serial_if_ml #(.DATA_WIDTH(10), .LANES(4), .CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[1]), .o_ready(ordy[1]), .i_data(id[1]),
    .o_valid(ov[1]), .o_data(od[1]), .o_busy(busy[1]), .ser_clk(sclk[1]),
    .ser_cs(scs[1]), .ser_data_out(sdo[1]), .ser_data_in(sdo[1]));

  parallel_serial_if_ml #(.DATA_WIDTH(8), .LANES(1), .CLK_DIV(3)) u2 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[2]), .o_ready(ordy[2]), .i_data(id[2][7:0]),
    .o_valid(ov[2]), .o_data(od[2][7:0]), .o_busy(busy[2]), .ser_clk(sclk[2]),
    .ser_cs(scs[2]), .ser_data_out(sdo[2][0:0]), .ser_data_in(sdo[2][0:0]));

  typedef struct {int u; logic [9:0] d;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int acc_cnt [NU] = '{default: 0};
  int ov_cnt  [NU] = '{default: 0};

  function automatic logic [9:0] wmask(input int u);
    logic [9:0] all1;
    all1 = 10'h3FF;
    return all1 >> (10 - cw[u]);
  endfunction

  // Scoreboard push: every accepted request expects its own payload back.
  always @(posedge clk) begin
    for (int u = 0; u < NU; u++)
      if (rst_n && iv[u] && ordy[u]) begin
        sbq.push_back('{u, id[u] & wmask(u)});
        acc_cnt[u]++;
      end
  end

  // Scoreboard pop on every o_valid pulse.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++)
      if (ov[u] === 1'b1) begin
        ov_cnt[u]++;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_valid unit=%0d got=%h required=none", u, od[u]);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.u != u || (od[u] & wmask(u)) !== mon_e.d) begin
            bad++;
            $display("FAIL sb_o_data unit=%0d got=%h required=%h (unit %0d)", u, od[u], mon_e.d, mon_e.u);
          end
        end
      end
  end

  task automatic chk_reset_vals(input int u, input string tag);
    total++;
    if ({ordy[u], busy[u], ov[u], scs[u], sclk[u]} !== 5'b10010) begin
      bad++;
      $display("FAIL %s_ctrl unit=%0d got=%b required=10010", tag, u,
               {ordy[u], busy[u], ov[u], scs[u], sclk[u]});
    end
    total++;
    if (sdo[u] !== 4'h0 || od[u] !== 10'h0) begin
      bad++;
      $display("FAIL %s_data unit=%0d got sdo=%h od=%h required 0/0", tag, u, sdo[u], od[u]);
    end
  endtask

  task automatic wait_ready(input int u);
    int wt = 0;
    while (ordy[u] !== 1'b1 && wt < 200) begin @(posedge clk); #1; wt++; end
    total++;
    if (ordy[u] !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout unit=%0d got=%b required=1", u, ordy[u]);
    end
  endtask

  task automatic run_frame(input int u, input logic [9:0] d);
    int beats, exp_cyc, rises, hi_n, lo_n, setup_n, hold_n, vcyc, hi_run, hi_max;
    logic prev;
    logic [15:0] sr;
    logic [3:0] seq [16];
    logic [3:0] lmask, ev;
    bit ok;
    beats   = (cw[u] + cl[u] - 1) / cl[u];
    exp_cyc = cd[u] * (2 * beats + 1) + 1;
    wait_ready(u);
    iv[u] = 1'b1; id[u] = d;
    @(posedge clk); #1;
    iv[u] = 1'b0; id[u] = ~d;  // must not disturb the frame in flight
    rises = 0; hi_n = 0; lo_n = 0; setup_n = 0; hold_n = 0; vcyc = 0; hi_run = 0; hi_max = 0;
    prev = 1'b0;
    for (int k = 0; k < 16; k++) seq[k] = '0;
    for (int n = 1; n <= 400; n++) begin
      if (sclk[u] && !prev) begin
        if (rises < 16) seq[rises] = sdo[u];
        rises++;
      end
      if (sclk[u]) begin
        hi_n++; hi_run++;
        if (hi_run > hi_max) hi_max = hi_run;
      end else hi_run = 0;
      if (!scs[u] && !sclk[u]) begin
        if (rises == 0) setup_n++; else lo_n++;
      end
      if (busy[u] && scs[u]) hold_n++;
      if (ov[u] && vcyc == 0) vcyc = n;
      prev = sclk[u];
      if (vcyc != 0 && ordy[u]) break;
      @(posedge clk); #1;
    end
    total++; if (vcyc != exp_cyc) begin bad++; $display("FAIL valid_cycle unit=%0d got=%0d required=%0d", u, vcyc, exp_cyc); end
    total++; if (rises != beats) begin bad++; $display("FAIL sclk_rises unit=%0d got=%0d required=%0d", u, rises, beats); end
    total++; if (hi_n != beats * cd[u] || hi_max != cd[u]) begin bad++; $display("FAIL sclk_high unit=%0d got total=%0d run=%0d required %0d/%0d", u, hi_n, hi_max, beats * cd[u], cd[u]); end
    total++; if (lo_n != beats * cd[u]) begin bad++; $display("FAIL sclk_low unit=%0d got=%0d required=%0d", u, lo_n, beats * cd[u]); end
    total++; if (setup_n != cd[u]) begin bad++; $display("FAIL setup_len unit=%0d got=%0d required=%0d", u, setup_n, cd[u]); end
    total++; if (hold_n != cd[u]) begin bad++; $display("FAIL hold_len unit=%0d got=%0d required=%0d", u, hold_n, cd[u]); end
    sr = 16'(d & wmask(u)) << (beats * cl[u] - cw[u]);
    lmask = 4'(16'hF >> (4 - cl[u]));
    ok = 1'b1;
    for (int k = 0; k < beats && k < 16; k++) begin
      ev = 4'(sr >> ((beats - 1 - k) * cl[u])) & lmask;
      if (seq[k] !== ev) begin
        ok = 1'b0;
        $display("FAIL lane_beat unit=%0d beat=%0d got=%h required=%h", u, k, seq[k], ev);
      end
    end
    total++; if (!ok) bad++;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ((od[u] & wmask(u)) !== (d & wmask(u))) begin
      bad++;
      $display("FAIL o_data_hold unit=%0d got=%h required=%h", u, od[u], d & wmask(u));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) chk_reset_vals(u, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_lane();
    run_frame(0, 10'h0A5);
    run_frame(0, 10'h0FF);
    run_frame(0, 10'h001);
  endtask

  task automatic test_multi_lane();
    run_frame(1, 10'h2D3);
    run_frame(1, 10'h3FF);
    run_frame(1, 10'h201);
  endtask

  task automatic test_clk_div();
    run_frame(2, 10'h0A5);
    run_frame(2, 10'h03C);
  endtask

  task automatic test_back_to_back();
    int a0, v0, gap, wt;
    bit cs_low_seen;
    wait_ready(0);
    a0 = acc_cnt[0]; v0 = ov_cnt[0];
    iv[0] = 1'b1; id[0] = 10'h05A;
    wt = 0;
    while (acc_cnt[0] == a0 && wt < 50) begin @(posedge clk); #1; wt++; end
    id[0] = 10'h0C3;
    gap = 0; cs_low_seen = 1'b0; wt = 0;
    while (acc_cnt[0] < a0 + 2 && wt < 100) begin
      if (cs_low_seen && scs[0]) gap++;
      if (!scs[0]) cs_low_seen = 1'b1;
      @(posedge clk); #1; wt++;
    end
    iv[0] = 1'b0;
    total++;
    if (gap != cd[0] + 1) begin bad++; $display("FAIL b2b_cs_gap got=%0d required=%0d", gap, cd[0] + 1); end
    wt = 0;
    while ((sbq.size() != 0 || ordy[0] !== 1'b1) && wt < 200) begin @(posedge clk); #1; wt++; end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (acc_cnt[0] - a0 != 2 || ov_cnt[0] - v0 != 2) begin
      bad++;
      $display("FAIL b2b_frames got accepts=%0d valids=%0d required 2/2", acc_cnt[0] - a0, ov_cnt[0] - v0);
    end
  endtask

  task automatic test_mid_reset();
    int rises, wt, v0;
    logic prev;
    wait_ready(0);
    iv[0] = 1'b1; id[0] = 10'h03C;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    rises = 0; prev = 1'b0; wt = 0;
    while (rises < 4 && wt < 100) begin
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      if (rises < 4) begin @(posedge clk); #1; end
      wt++;
    end
    total++;
    if (rises != 4) begin bad++; $display("FAIL midrst_reach_beat3 got=%0d required=4", rises); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    chk_reset_vals(0, "midrst");
    v0 = ov_cnt[0];
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (ov_cnt[0] != v0 || od[0] !== 10'h0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_valid got valids=%0d od=%h busy=%b required 0/0/0", ov_cnt[0] - v0, od[0], busy[0]);
    end
    run_frame(0, 10'h096);
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_multi_lane();
    test_clk_div();
    test_back_to_back();
    test_mid_reset();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
